anc_sched: RTL and testbench
============================

# anc_sched

Sample-rate scheduler for the adaptive FIR engine.
- Accepts one reference/error sample pair per audio frame and computes the LMS weight step `mu*err`.
- Launches one FIR pass per frame, waits for completion and publishes the anti-noise sample.
- Arbitrates the engine's scan port against normal operation.
- Sits between the audio front-end (ADC/DAC framing) and the FIR engine; it is the only block that drives the engine's `fir_go`, `x_in`, `a_in`, `weight_adjust` and `scan_en`.

## Interface
Parameters:
- `WAIT_MAX`, 320: cycles allowed in WAIT before timeout. Must exceed the engine's pass length of TAPS+7 cycles after `fir_go`.
- `CNT_W`, 8: overrun counter width.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe, new frame.
- `ref_sample` in 16s: reference mic sample, q1.15.
- `err_sample` in 16s: error mic sample, q1.15.
- `mu` in 16s: LMS step size, q1.15.
- `adapt_en` in 1: 0 forces `weight_adjust` to 0 (weights frozen).
- `a_bias` in 16s: accumulator preload, passed to the engine `a_in`.
- `scan_req` in 1: test request for weight/sample scan-out.
- `scan_grant` out 1: high while in SCAN.
- `fir_x` out 16s: to engine `x_in`.
- `fir_a` out 16s: to engine `a_in`.
- `fir_wadj` out 16s: to engine `weight_adjust`.
- `fir_go` out 1: to engine `fir_go`.
- `fir_scan_en` out 1: to engine `scan_en`.
- `fir_done` in 1: from engine `done`.
- `fir_out` in 16s: from engine `out_sample`.
- `y_out` out 16s: anti-noise sample, held between updates.
- `y_valid` out 1: one-cycle strobe with each new `y_out`.
- `busy` out 1: state is not IDLE.
- `overrun_cnt` out CNT_W: dropped frames; saturates at all-ones.
- `timeout_err` out 1: sticky; cleared only by reset.

## Operation
State machine: IDLE, LOAD, GO, WAIT, SCAN.

- **IDLE**
  - `sample_valid`: register `ref_sample`, `err_sample`, `mu`, `adapt_en` and `a_bias`, then go to LOAD.
  - Else if `scan_req`: go to SCAN.
  - `sample_valid` has priority over `scan_req` when both are asserted.
- **LOAD**
  - `fir_x` is set to the registered ref sample and `fir_a` to the registered bias.
  - `fir_wadj = adapt_en ? sat16(p[31:15]) : 0`, where `p = mu*err` (signed 32-bit).
  - Rounding is truncation.
  - The only overflow is (-1)·(-1); that case yields 0x7FFF.
  - Next state: GO.
- **GO**: `fir_go=1` for exactly this cycle. Next state: WAIT; the timeout counter is cleared.
- **WAIT**
  - `fir_done`: capture `fir_out` into `y_out`, pulse `y_valid` on the next cycle, go to IDLE.
  - Counter reaches WAIT_MAX-1 with no done: set `timeout_err`, leave `y_out` unchanged, no `y_valid`, go to IDLE.
  - Engine recovery after a timeout requires `rst_n`.
- **SCAN**
  - `fir_scan_en=scan_grant=1`.
  - When `scan_req` deasserts, go to IDLE; `fir_scan_en` drops the same cycle the state leaves.
- **Hold rule**: `fir_x`, `fir_a` and `fir_wadj` hold their LOAD values until the next LOAD.
- **Overrun**: `sample_valid` in any state other than IDLE drops the frame and increments `overrun_cnt`, saturating.
- **Reset**
  - All outputs are 0, including `y_out`, `overrun_cnt`, `timeout_err`, `fir_go` and `fir_scan_en`; state is IDLE.
  - Reset mid-WAIT or mid-SCAN returns to IDLE immediately; the engine shares `rst_n`.

## Timing
- `sample_valid` sampled at edge 0: LOAD in cycle 1, `fir_go` high in cycle 2, WAIT from cycle 3.
- `fir_done` high in cycle k: `y_valid` and the new `y_out` in cycle k+1, IDLE in k+1.
- A new frame is accepted in cycle k+1.
- `fir_done` in the same cycle as an expiring timeout counts as done; no error is set.
- `fir_done` outside WAIT is ignored.
- Minimum frame spacing without overrun is TAPS+10 cycles.
- `busy` is registered from state.
- `scan_grant` is asserted one cycle after `scan_req` is sampled in IDLE.

## Structure
- Shared package `anc_pkg`:
  - state enum.
  - q1.15 constants: `Q15_MAX=16'sh7FFF`, `Q15_MIN=16'sh8000`.
  - `sat16` function.
  - default `WAIT_MAX`.
- Instantiate one `bw_mult` for `mu*err`, shared with the engine's multiplier style.
- Reuse the existing `saturate #(17,16)` for the product; no other sub-modules.

## Test plan
- `mu`=0x4000 (0.5), err=0x2000, adapt_en=1 -> `fir_wadj`=0x1000; one `fir_go`, in cycle 2 after the strobe.
- `mu`=0x8000, err=0x8000 -> `fir_wadj`=0x7FFF. With adapt_en=0, any product -> `fir_wadj`=0.
- Engine stub returns done with `fir_out`=0x1234 at cycle 265 -> `y_out`=0x1234 and `y_valid` in cycle 266; `busy` falls the same cycle.
- Three strobes at spacing 100 -> the 2nd and 3rd are dropped and `overrun_cnt`=2. 300 overruns -> `overrun_cnt`=255.
- Stub never asserts done -> `timeout_err`=1 after 320 WAIT cycles, `y_out` unchanged, next frame accepted.
- `scan_req` and `sample_valid` asserted together in IDLE -> frame processed first, then SCAN.
  - `sample_valid` during SCAN -> overrun.
  - `rst_n` pulsed mid-SCAN -> `fir_scan_en`=0 asynchronously.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared definitions for the ANC sample scheduler.
//   state_e      : scheduler states
//   Q15_MAX/MIN  : q1.15 saturation limits
//   WAIT_MAX_DEF : default number of WAIT cycles before a pass is declared lost
//   sat16()      : clamp a 17-bit signed value into q1.15
package anc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGo,
    StWait,
    StScan
  } state_e;

  localparam logic [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic [15:0] Q15_MIN = 16'sh8000;

  localparam int unsigned WAIT_MAX_DEF = 320;

  // In range iff the two top bits agree; otherwise clamp toward the sign.
  function automatic logic [15:0] sat16(input logic [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? Q15_MIN : Q15_MAX;
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/bw_mult.sv
// Baugh-Wooley signed multiplier, purely combinational.
//   a_i, b_i : W-bit two's-complement operands
//   p_o      : 2W-bit two's-complement product
module bw_mult #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] acc;
  logic          pp;

  always_comb begin
    acc = '0;
    pp  = 1'b0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        pp = a_i[i] & b_i[j];
        // Partial products that mix exactly one sign bit enter inverted.
        if ((i == W - 1) != (j == W - 1)) begin
          pp = ~pp;
        end
        acc = acc + (PW'(pp) << (i + j));
      end
    end
    // Constant correction for the inverted rows.
    acc = acc + (PW'(1) << W) + (PW'(1) << (PW - 1));
  end

  assign p_o = acc;

endmodule

// File: rtl/saturate.sv
// Signed width reduction with saturation.
//   d_i : IN_W-bit two's-complement input
//   q_o : OUT_W-bit result, clamped to the most positive/negative value on overflow
module saturate #(
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IN_W-1:0]  d_i,
  output logic [OUT_W-1:0] q_o
);

  // Bits from the output sign position upward must all match to be in range.
  logic [IN_W-OUT_W:0] top;
  assign top = d_i[IN_W-1:OUT_W-1];

  always_comb begin
    if (top == '0 || top == '1) begin
      q_o = d_i[OUT_W-1:0];
    end else if (d_i[IN_W-1]) begin
      q_o = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      q_o = {1'b0, {(OUT_W - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/anc_sched.sv
// Sample-rate scheduler for the adaptive FIR engine.
// Takes one reference/error pair per frame, computes the LMS step mu*err, launches one FIR
// pass, waits for done (bounded by WAIT_MAX) and publishes the anti-noise sample. Also
// grants the engine's scan port when idle.
//   sample_valid, ref_sample, err_sample, mu, adapt_en, a_bias : frame inputs
//   scan_req / scan_grant                                      : scan arbitration
//   fir_x, fir_a, fir_wadj, fir_go, fir_scan_en                : engine controls
//   fir_done, fir_out                                          : engine results
//   y_out, y_valid                                             : published sample + strobe
//   busy, overrun_cnt, timeout_err                             : status
module anc_sched
  import anc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [15:0]      ref_sample,
  input  logic [15:0]      err_sample,
  input  logic [15:0]      mu,
  input  logic             adapt_en,
  input  logic [15:0]      a_bias,
  input  logic             scan_req,
  output logic             scan_grant,
  output logic [15:0]      fir_x,
  output logic [15:0]      fir_a,
  output logic [15:0]      fir_wadj,
  output logic             fir_go,
  output logic             fir_scan_en,
  input  logic             fir_done,
  input  logic [15:0]      fir_out,
  output logic [15:0]      y_out,
  output logic             y_valid,
  output logic             busy,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic             timeout_err
);

  localparam int unsigned TmrW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(WAIT_MAX - 1);

  state_e state_q, state_d;

  logic [15:0]      ref_q, ref_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      mu_q, mu_d;
  logic [15:0]      bias_q, bias_d;
  logic             adapt_q, adapt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [15:0]      fir_x_q, fir_x_d;
  logic [15:0]      fir_a_q, fir_a_d;
  logic [15:0]      fir_wadj_q, fir_wadj_d;
  logic             fir_go_q, fir_go_d;
  logic             scan_q, scan_d;
  logic [15:0]      y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] ovr_q, ovr_d;
  logic             terr_q, terr_d;

  // mu*err in q2.30; bits [31:15] are the truncated q1.15 result plus one guard bit.
  logic [31:0] prod;
  logic [15:0] wadj_sat;
  logic        unused_prod_lsb;

  bw_mult #(
    .W(16)
  ) u_mult (
    .a_i(mu_q),
    .b_i(err_q),
    .p_o(prod)
  );

  saturate #(
    .IN_W (17),
    .OUT_W(16)
  ) u_sat (
    .d_i(prod[31:15]),
    .q_o(wadj_sat)
  );

  assign unused_prod_lsb = ^prod[14:0];

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    err_d      = err_q;
    mu_d       = mu_q;
    bias_d     = bias_q;
    adapt_d    = adapt_q;
    tmr_d      = tmr_q;
    fir_x_d    = fir_x_q;
    fir_a_d    = fir_a_q;
    fir_wadj_d = fir_wadj_q;
    y_d        = y_q;
    y_valid_d  = 1'b0;
    ovr_d      = ovr_q;
    terr_d     = terr_q;

    // A frame arriving while any pass or scan is in progress is dropped.
    if (sample_valid && (state_q != StIdle) && (ovr_q != '1)) begin
      ovr_d = ovr_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (sample_valid) begin
          ref_d   = ref_sample;
          err_d   = err_sample;
          mu_d    = mu;
          bias_d  = a_bias;
          adapt_d = adapt_en;
          state_d = StLoad;
        end else if (scan_req) begin
          state_d = StScan;
        end
      end
      StLoad: begin
        fir_x_d    = ref_q;
        fir_a_d    = bias_q;
        fir_wadj_d = adapt_q ? wadj_sat : 16'h0000;
        state_d    = StGo;
      end
      StGo: begin
        tmr_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done wins over an expiring timer in the same cycle.
        if (fir_done) begin
          y_d       = fir_out;
          y_valid_d = 1'b1;
          state_d   = StIdle;
        end else if (tmr_q == TmrLast) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StScan: begin
        if (!scan_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered decodes of the next state so they align with the state itself.
    fir_go_d = (state_d == StGo);
    scan_d   = (state_d == StScan);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ref_q      <= '0;
      err_q      <= '0;
      mu_q       <= '0;
      bias_q     <= '0;
      adapt_q    <= 1'b0;
      tmr_q      <= '0;
      fir_x_q    <= '0;
      fir_a_q    <= '0;
      fir_wadj_q <= '0;
      fir_go_q   <= 1'b0;
      scan_q     <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      err_q      <= err_d;
      mu_q       <= mu_d;
      bias_q     <= bias_d;
      adapt_q    <= adapt_d;
      tmr_q      <= tmr_d;
      fir_x_q    <= fir_x_d;
      fir_a_q    <= fir_a_d;
      fir_wadj_q <= fir_wadj_d;
      fir_go_q   <= fir_go_d;
      scan_q     <= scan_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      terr_q     <= terr_d;
    end
  end

  assign fir_x       = fir_x_q;
  assign fir_a       = fir_a_q;
  assign fir_wadj    = fir_wadj_q;
  assign fir_go      = fir_go_q;
  assign fir_scan_en = scan_q;
  assign scan_grant  = scan_q;
  assign y_out       = y_q;
  assign y_valid     = y_valid_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_anc_sched.sv
// Self-checking bench for anc_sched: frame-level reference model with randomized samples,
// engine latencies and overrun strobes, plus directed scan and reset scenarios.
module tb_anc_sched;

  localparam int unsigned WaitMax = 320;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [15:0] ref_sample, err_sample, mu, a_bias;
  logic        adapt_en;
  logic        scan_req;
  logic        scan_grant;
  logic [15:0] fir_x, fir_a, fir_wadj;
  logic        fir_go, fir_scan_en;
  logic        fir_done;
  logic [15:0] fir_out;
  logic [15:0] y_out;
  logic        y_valid, busy;
  logic [7:0]  overrun_cnt;
  logic        timeout_err;

  always #5 clk = ~clk;

  anc_sched #(
    .WAIT_MAX(WaitMax),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .ref_sample  (ref_sample),
    .err_sample  (err_sample),
    .mu          (mu),
    .adapt_en    (adapt_en),
    .a_bias      (a_bias),
    .scan_req    (scan_req),
    .scan_grant  (scan_grant),
    .fir_x       (fir_x),
    .fir_a       (fir_a),
    .fir_wadj    (fir_wadj),
    .fir_go      (fir_go),
    .fir_scan_en (fir_scan_en),
    .fir_done    (fir_done),
    .fir_out     (fir_out),
    .y_out       (y_out),
    .y_valid     (y_valid),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [15:0] exp_y, exp_x, exp_a, exp_w;
  logic        exp_terr;
  int          exp_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // LMS step: q1.15 product truncated toward -inf, clamped to q1.15 range.
  function automatic logic [15:0] model_wadj(input logic [15:0] m, input logic [15:0] e,
                                             input logic ad);
    int p, q;
    if (!ad) return 16'h0000;
    p = $signed(m) * $signed(e);
    q = p >>> 15;
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return 16'(q);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_ovr();
    if (exp_ovr < 255) exp_ovr++;
  endtask

  // Runs one frame strobed in the current cycle (cycle 0). done_at is the cycle index at which
  // the stub engine raises fir_done (negative: never). early drives done during LOAD/GO.
  // Returns in the first cycle after the pass, with the scheduler back in IDLE.
  task automatic run_frame(input logic [15:0] r, input logic [15:0] e, input logic [15:0] m,
                           input logic [15:0] b, input logic ad, input logic early,
                           input int done_at, input logic [15:0] dout, input int ovr_every);
    int  end_cycle;
    int  bad_busy, bad_go, bad_yv;
    logic done_ok;
    ref_sample   = r;
    err_sample   = e;
    mu           = m;
    a_bias       = b;
    adapt_en     = ad;
    sample_valid = 1'b1;
    tick();  // cycle 1
    sample_valid = 1'b0;
    ref_sample   = 16'($urandom);
    err_sample   = 16'($urandom);
    mu           = 16'($urandom);
    a_bias       = 16'($urandom);
    adapt_en     = 1'($urandom);
    fir_done     = early;
    fir_out      = 16'($urandom);
    check_eq("busy_load", 32'(busy), 32'd1);
    check_eq("go_early", 32'(fir_go), 32'd0);
    check_eq("yvalid_once", 32'(y_valid), 32'd0);
    tick();  // cycle 2
    fir_out = 16'($urandom);
    exp_x   = r;
    exp_a   = b;
    exp_w   = model_wadj(m, e, ad);
    check_eq("go_pulse", 32'(fir_go), 32'd1);
    check_eq("fir_x", 32'(fir_x), 32'(exp_x));
    check_eq("fir_a", 32'(fir_a), 32'(exp_a));
    check_eq("fir_wadj", 32'(fir_wadj), 32'(exp_w));

    done_ok   = (done_at >= 3) && (done_at <= 3 + int'(WaitMax) - 1);
    end_cycle = done_ok ? done_at + 1 : 3 + int'(WaitMax);
    bad_busy  = 0;
    bad_go    = 0;
    bad_yv    = 0;
    for (int c = 3; c < end_cycle; c++) begin
      tick();
      if (busy !== 1'b1) bad_busy++;
      if (fir_go !== 1'b0) bad_go++;
      if (y_valid !== 1'b0) bad_yv++;
      fir_done = (c == done_at);
      fir_out  = (c == done_at) ? dout : 16'($urandom);
      sample_valid = (ovr_every > 0) && (c % ovr_every == 0);
      if (sample_valid) begin
        ref_sample = 16'($urandom);
        bump_ovr();
      end
    end
    tick();  // end_cycle
    fir_done     = 1'b0;
    sample_valid = 1'b0;
    check_eq("busy_wait", 32'(bad_busy), 32'd0);
    check_eq("single_go", 32'(bad_go), 32'd0);
    check_eq("yvalid_wait", 32'(bad_yv), 32'd0);
    if (done_ok) exp_y = dout;
    else exp_terr = 1'b1;
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("yvalid_end", 32'(y_valid), 32'(done_ok));
    check_eq("y_out", 32'(y_out), 32'(exp_y));
    check_eq("timeout_err", 32'(timeout_err), 32'(exp_terr));
    check_eq("overrun_cnt", 32'(overrun_cnt), 32'(exp_ovr));
    check_eq("wadj_hold", 32'(fir_wadj), 32'(exp_w));
    check_eq("x_hold", 32'(fir_x), 32'(exp_x));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_x"}, 32'(fir_x), 32'd0);
    check_eq({tag, "_a"}, 32'(fir_a), 32'd0);
    check_eq({tag, "_wadj"}, 32'(fir_wadj), 32'd0);
    check_eq({tag, "_go"}, 32'(fir_go), 32'd0);
    check_eq({tag, "_scan_en"}, 32'(fir_scan_en), 32'd0);
    check_eq({tag, "_grant"}, 32'(scan_grant), 32'd0);
    check_eq({tag, "_y"}, 32'(y_out), 32'd0);
    check_eq({tag, "_yvalid"}, 32'(y_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_ovr"}, 32'(overrun_cnt), 32'd0);
    check_eq({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, e, m, b, d;
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    ref_sample   = '0;
    err_sample   = '0;
    mu           = '0;
    a_bias       = '0;
    adapt_en     = 1'b0;
    scan_req     = 1'b0;
    fir_done     = 1'b0;
    fir_out      = '0;
    exp_y        = '0;
    exp_x        = '0;
    exp_a        = '0;
    exp_w        = '0;
    exp_terr     = 1'b0;
    exp_ovr      = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    #2 rst_n = 1'b1;
    tick();

    // 0.5 * 0.25 = 0.125; done at 265, strobes at 100 and 200 are dropped.
    run_frame(16'h1111, 16'h2000, 16'h4000, 16'h0042, 1'b1, 1'b0, 265, 16'h1234, 100);
    // (-1)*(-1) is the only overflowing product.
    run_frame(16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 40, 16'hBEEF, 0);
    // Adaptation disabled freezes the weights.
    run_frame(16'h0F0F, 16'h7123, 16'h6543, 16'h0001, 1'b0, 1'b0, 12, 16'h5555, 0);

    for (int k = 0; k < 6; k++) begin
      r = 16'($urandom);
      e = 16'($urandom);
      m = 16'($urandom);
      b = 16'($urandom);
      d = 16'($urandom);
      run_frame(r, e, m, b, 1'($urandom), 1'b0, int'($urandom_range(3, 300)), d,
                (k % 2 == 1) ? int'($urandom_range(20, 120)) : 0);
    end

    // Done arriving together with the last timer cycle counts as done.
    run_frame(16'h0123, 16'hC000, 16'h4000, 16'h0002, 1'b1, 1'b0, 3 + int'(WaitMax) - 1,
              16'h0ACE, 0);

    // Frame and scan requested together: frame first, then SCAN.
    scan_req = 1'b1;
    run_frame(16'h2222, 16'h0800, 16'h7FFF, 16'h0003, 1'b1, 1'b0, 20, 16'h7777, 0);
    tick();
    check_eq("scan_grant", 32'(scan_grant), 32'd1);
    check_eq("scan_en", 32'(fir_scan_en), 32'd1);
    check_eq("scan_busy", 32'(busy), 32'd1);
    check_eq("scan_yvalid", 32'(y_valid), 32'd0);
    sample_valid = 1'b1;
    bump_ovr();
    tick();
    sample_valid = 1'b0;
    check_eq("scan_ovr", 32'(overrun_cnt), 32'(exp_ovr));
    check_eq("scan_hold", 32'(scan_grant), 32'd1);
    check_eq("scan_wadj_hold", 32'(fir_wadj), 32'(exp_w));
    scan_req = 1'b0;
    tick();
    check_eq("scan_exit_grant", 32'(fir_scan_en), 32'd0);
    check_eq("scan_exit_busy", 32'(busy), 32'd0);
    scan_req = 1'b1;
    tick();
    check_eq("scan_reenter", 32'(scan_grant), 32'd1);

    // Asynchronous reset in the middle of a scan cycle.
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("rst_scan");
    scan_req = 1'b0;
    #1 rst_n = 1'b1;
    exp_y    = '0;
    exp_x    = '0;
    exp_a    = '0;
    exp_w    = '0;
    exp_terr = 1'b0;
    exp_ovr  = 0;
    tick();
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Done during LOAD/GO is ignored; the engine then never finishes. Every WAIT cycle
    // carries a strobe, which saturates the overrun counter.
    run_frame(16'h3333, 16'h1000, 16'h1000, 16'h0004, 1'b1, 1'b1, -1, 16'h0000, 1);
    // Next frame is accepted right after the timeout.
    run_frame(16'h4444, 16'hF000, 16'h2000, 16'h0005, 1'b1, 1'b0, 50, 16'h9ABC, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
